// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard/forwarding controller and the EX operand muxes.
// Select encodings must match the mux wiring in EX.
package hazard_forward_unit_pkg;

  localparam logic [1:0] FWD_EXMEM = 2'd2;
  localparam logic [1:0] FWD_MEMWB = 2'd1;
  localparam logic [1:0] FWD_RF    = 2'd0;

  typedef enum logic {
    MULT_IDLE = 1'b0,
    MULT_BUSY = 1'b1
  } mult_state_t;

  // A load in EX has no result yet, so an EX match from a load falls through to MEM.
  function automatic logic [1:0] fwd_select(input logic ex_hit, input logic ex_mem_read,
                                            input logic mem_hit);
    if (ex_hit && !ex_mem_read) return FWD_EXMEM;
    else if (mem_hit)           return FWD_MEMWB;
    else                        return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_mult_stall_ctr.sv
// Multi-cycle multiply occupancy tracker: holds EX for MULT_LAT-1 cycles,
// then gives one release cycle in which a new multiply cannot start.
module mult_stall_ctr
  import hazard_forward_unit_pkg::*;
#(
  parameter int MULT_LAT = 3
) (
  input  logic clk,
  input  logic arst,
  input  logic start,
  output logic hold_ex,
  output logic mult_busy
);

  localparam int CNT_W = (MULT_LAT > 2) ? $clog2(MULT_LAT - 1) : 1;
  localparam logic MULTI_CYCLE = (MULT_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = MULTI_CYCLE ? CNT_W'(MULT_LAT - 2) : '0;

  mult_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg <= MULT_IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        MULT_IDLE: begin
          if (start && MULTI_CYCLE) begin
            state_reg <= MULT_BUSY;
            cnt_reg   <= CNT_LOAD;
            busy_reg  <= 1'b1;
          end
        end
        MULT_BUSY: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            state_reg <= MULT_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= MULT_IDLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Hold starts in the multiply's first EX cycle, before the FSM has left IDLE.
  assign hold_ex   = (state_reg == MULT_IDLE) ? (start & MULTI_CYCLE) : (cnt_reg != '0);
  assign mult_busy = busy_reg;

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding-select registers, load-use detection and stall/flush generation
// for the 5-stage pipeline; multiply holds come from mult_stall_ctr.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MULT_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_is_mult,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if,
  output logic                  flush_id_ex,
  output logic                  hold_ex,
  output logic                  mult_busy
);

  logic [1:0][REG_ADDR_W-1:0] rs_addr;
  logic [1:0]                 ex_hit;
  logic [1:0]                 mem_hit;
  logic [1:0][1:0]            sel_bus;
  logic                       load_use;

  assign rs_addr = {id_rs2, id_rs1};

  mult_stall_ctr #(
    .MULT_LAT (MULT_LAT)
  ) u_mult_stall_ctr (
    .clk       (clk),
    .arst      (arst),
    .start     (ex_valid & ex_is_mult),
    .hold_ex   (hold_ex),
    .mult_busy (mult_busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      logic [1:0] sel_next;
      logic [1:0] sel_reg;

      // x0 is hardwired zero, so it never forwards.
      assign ex_hit[gi]  = ex_valid & ex_reg_write & (rs_addr[gi] != '0) & (ex_rd == rs_addr[gi]);
      assign mem_hit[gi] = mem_reg_write & (rs_addr[gi] != '0) & (mem_rd == rs_addr[gi]);

      always_comb begin
        sel_next = FWD_RF;
        if (id_valid) sel_next = fwd_select(ex_hit[gi], ex_mem_read, mem_hit[gi]);
      end

      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          sel_reg <= FWD_RF;
        end else if (!hold_ex) begin
          sel_reg <= flush_id_ex ? FWD_RF : sel_next;
        end
      end

      assign sel_bus[gi] = sel_reg;
    end
  endgenerate

  assign load_use    = id_valid & ex_mem_read & (ex_hit[0] | ex_hit[1]);
  assign stall_if    = hold_ex | load_use;
  assign flush_id_ex = load_use & ~hold_ex;
  assign fwd_a_sel   = sel_bus[0];
  assign fwd_b_sel   = sel_bus[1];

endmodule
